// File: rtl/nebula_mem_arbiter.sv
// Round-robin arbiter merging the Nebula core's imem, dmem and ptw channels onto one line-wide bus.
// Optional bus-ack watchdog enabled by defining NEBULA_ARB_TIMEOUT_EN.
module nebula_mem_arbiter #(
  parameter int PADDR_WIDTH    = 56,
  parameter int XLEN           = 64,
  parameter int LINE_BYTES     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      imem_req,
  input  logic [PADDR_WIDTH-1:0]    imem_addr,
  output logic                      imem_ack,
  output logic [LINE_BYTES*8-1:0]   imem_data,
  output logic                      imem_error,
  input  logic                      dmem_req,
  input  logic                      dmem_we,
  input  logic [PADDR_WIDTH-1:0]    dmem_addr,
  input  logic [LINE_BYTES*8-1:0]   dmem_wdata,
  input  logic                      dmem_is_amo,
  input  logic [4:0]                dmem_amo_op,
  output logic                      dmem_ack,
  output logic [LINE_BYTES*8-1:0]   dmem_rdata,
  output logic                      dmem_error,
  input  logic                      ptw_mem_req,
  input  logic [PADDR_WIDTH-1:0]    ptw_mem_addr,
  output logic                      ptw_mem_ack,
  output logic [XLEN-1:0]           ptw_mem_data,
  output logic                      ptw_mem_error,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [PADDR_WIDTH-1:0]    bus_addr,
  output logic [LINE_BYTES*8-1:0]   bus_wdata,
  output logic                      bus_is_amo,
  output logic [4:0]                bus_amo_op,
  input  logic                      bus_ack,
  input  logic [LINE_BYTES*8-1:0]   bus_rdata,
  input  logic                      bus_error
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = OFF_W - 3;
  localparam logic [PADDR_WIDTH-1:0] OFF_MASK = PADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_e;
  typedef enum logic [1:0] {M_IMEM = 2'd0, M_DMEM = 2'd1, M_PTW = 2'd2} master_e;

  // First requester strictly after the last grant; only meaningful when some request is high.
  function automatic master_e rr_pick(input master_e last, input logic [2:0] reqs);
    master_e g;
    case (last)
      M_IMEM:  g = reqs[1] ? M_DMEM : (reqs[2] ? M_PTW : M_IMEM);
      M_DMEM:  g = reqs[2] ? M_PTW : (reqs[0] ? M_IMEM : M_DMEM);
      default: g = reqs[0] ? M_IMEM : (reqs[1] ? M_DMEM : M_PTW);
    endcase
    return g;
  endfunction

  state_e                 state_q, state_d;
  master_e                last_q, last_d, grant_s;
  logic                   bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_is_amo_q, bus_is_amo_d;
  logic [PADDR_WIDTH-1:0] bus_addr_q, bus_addr_d, req_addr_s;
  logic [LINE_W-1:0]      bus_wdata_q, bus_wdata_d, resp_line_s;
  logic [4:0]             bus_amo_op_q, bus_amo_op_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   imem_ack_q, imem_ack_d, dmem_ack_q, dmem_ack_d, ptw_ack_q, ptw_ack_d;
  logic                   imem_err_q, imem_err_d, dmem_err_q, dmem_err_d, ptw_err_q, ptw_err_d;
  logic [LINE_W-1:0]      imem_data_q, imem_data_d, dmem_rdata_q, dmem_rdata_d;
  logic [XLEN-1:0]        ptw_data_q, ptw_data_d;
  logic [2:0]             req_vec_s;
  logic                   done_s, resp_err_s;
`ifdef NEBULA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

  // Next-state, bus request capture and response steering.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_is_amo_d = bus_is_amo_q;
    bus_amo_op_d = bus_amo_op_q;
    idx_d        = idx_q;
    imem_ack_d   = 1'b0;
    dmem_ack_d   = 1'b0;
    ptw_ack_d    = 1'b0;
    imem_err_d   = imem_err_q;
    dmem_err_d   = dmem_err_q;
    ptw_err_d    = ptw_err_q;
    imem_data_d  = imem_data_q;
    dmem_rdata_d = dmem_rdata_q;
    ptw_data_d   = ptw_data_q;
    req_vec_s    = {ptw_mem_req, dmem_req, imem_req};
    grant_s      = rr_pick(last_q, req_vec_s);
    req_addr_s   = imem_addr;
    done_s       = 1'b0;
    resp_err_s   = 1'b0;
`ifdef NEBULA_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_vec_s) begin
          state_d   = S_BUSY;
          last_d    = grant_s;
          bus_req_d = 1'b1;
          case (grant_s)
            M_IMEM:  req_addr_s = imem_addr;
            M_DMEM:  req_addr_s = dmem_addr;
            default: req_addr_s = ptw_mem_addr;
          endcase
          bus_addr_d   = req_addr_s & ~OFF_MASK;
          bus_we_d     = (grant_s == M_DMEM) ? dmem_we : 1'b0;
          bus_wdata_d  = (grant_s == M_DMEM) ? dmem_wdata : {LINE_W{1'b0}};
          bus_is_amo_d = (grant_s == M_DMEM) ? dmem_is_amo : 1'b0;
          bus_amo_op_d = (grant_s == M_DMEM) ? dmem_amo_op : 5'd0;
          idx_d        = ptw_mem_addr[OFF_W-1:3];
`ifdef NEBULA_ARB_TIMEOUT_EN
          cnt_d        = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (bus_ack) begin
          bus_req_d  = 1'b0;
          state_d    = S_RESP;
          done_s     = 1'b1;
          resp_err_s = bus_error;
        end else begin
`ifdef NEBULA_ARB_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_req_d  = 1'b0;
            state_d    = S_RESP;
            done_s     = 1'b1;
            resp_err_s = 1'b1;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = S_BUSY;
`endif
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An errored or timed-out transfer returns zero data to the master.
    resp_line_s = resp_err_s ? {LINE_W{1'b0}} : bus_rdata;
    if (done_s) begin
      case (last_q)
        M_IMEM: begin
          imem_ack_d  = 1'b1;
          imem_data_d = resp_line_s;
          imem_err_d  = resp_err_s;
        end
        M_DMEM: begin
          dmem_ack_d   = 1'b1;
          dmem_rdata_d = resp_line_s;
          dmem_err_d   = resp_err_s;
        end
        default: begin
          ptw_ack_d  = 1'b1;
          ptw_data_d = resp_line_s[idx_q*XLEN +: XLEN];
          ptw_err_d  = resp_err_s;
        end
      endcase
    end else begin
      imem_ack_d = 1'b0;
      dmem_ack_d = 1'b0;
      ptw_ack_d  = 1'b0;
    end
  end

  // State and output registers; reset drops bus_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= M_PTW;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= {PADDR_WIDTH{1'b0}};
      bus_wdata_q  <= {LINE_W{1'b0}};
      bus_is_amo_q <= 1'b0;
      bus_amo_op_q <= 5'd0;
      idx_q        <= {IDX_W{1'b0}};
      imem_ack_q   <= 1'b0;
      dmem_ack_q   <= 1'b0;
      ptw_ack_q    <= 1'b0;
      imem_err_q   <= 1'b0;
      dmem_err_q   <= 1'b0;
      ptw_err_q    <= 1'b0;
      imem_data_q  <= {LINE_W{1'b0}};
      dmem_rdata_q <= {LINE_W{1'b0}};
      ptw_data_q   <= {XLEN{1'b0}};
`ifdef NEBULA_ARB_TIMEOUT_EN
      cnt_q        <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_is_amo_q <= bus_is_amo_d;
      bus_amo_op_q <= bus_amo_op_d;
      idx_q        <= idx_d;
      imem_ack_q   <= imem_ack_d;
      dmem_ack_q   <= dmem_ack_d;
      ptw_ack_q    <= ptw_ack_d;
      imem_err_q   <= imem_err_d;
      dmem_err_q   <= dmem_err_d;
      ptw_err_q    <= ptw_err_d;
      imem_data_q  <= imem_data_d;
      dmem_rdata_q <= dmem_rdata_d;
      ptw_data_q   <= ptw_data_d;
`ifdef NEBULA_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_is_amo    = bus_is_amo_q;
  assign bus_amo_op    = bus_amo_op_q;
  assign imem_ack      = imem_ack_q;
  assign imem_data     = imem_data_q;
  assign imem_error    = imem_err_q;
  assign dmem_ack      = dmem_ack_q;
  assign dmem_rdata    = dmem_rdata_q;
  assign dmem_error    = dmem_err_q;
  assign ptw_mem_ack   = ptw_ack_q;
  assign ptw_mem_data  = ptw_data_q;
  assign ptw_mem_error = ptw_err_q;

endmodule

// File: tb/tb_nebula_mem_arbiter.sv
// Directed plus randomized bench for nebula_mem_arbiter with a round-robin reference model.
module tb_nebula_mem_arbiter;
  localparam int PW = 56;
  localparam int XL = 64;
  localparam int LB = 64;
  localparam int LW = LB * 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic imem_req, imem_ack, imem_error;
  logic [PW-1:0] imem_addr;
  logic [LW-1:0] imem_data;
  logic dmem_req, dmem_we, dmem_is_amo, dmem_ack, dmem_error;
  logic [PW-1:0] dmem_addr;
  logic [LW-1:0] dmem_wdata, dmem_rdata;
  logic [4:0] dmem_amo_op;
  logic ptw_mem_req, ptw_mem_ack, ptw_mem_error;
  logic [PW-1:0] ptw_mem_addr;
  logic [XL-1:0] ptw_mem_data;
  logic bus_req, bus_we, bus_is_amo, bus_ack, bus_error;
  logic [PW-1:0] bus_addr;
  logic [LW-1:0] bus_wdata, bus_rdata;
  logic [4:0] bus_amo_op;

  nebula_mem_arbiter #(.PADDR_WIDTH(PW), .XLEN(XL), .LINE_BYTES(LB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .imem_error(imem_error),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_is_amo(dmem_is_amo), .dmem_amo_op(dmem_amo_op), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
    .ptw_mem_req(ptw_mem_req), .ptw_mem_addr(ptw_mem_addr), .ptw_mem_ack(ptw_mem_ack),
    .ptw_mem_data(ptw_mem_data), .ptw_mem_error(ptw_mem_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_is_amo(bus_is_amo), .bus_amo_op(bus_amo_op), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_error(bus_error)
  );

  int checks = 0;
  int errors = 0;
  int last_grant = 2;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round robin: masters 0=I, 1=D, 2=P; search starts after last grant.
  function automatic int pick(input bit [2:0] reqs);
    for (int k = 1; k <= 3; k++) begin
      int m;
      m = (last_grant + k) % 3;
      if (reqs[m]) return m;
    end
    return -1;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [PW-1:0] line_base(input logic [PW-1:0] a);
    return (a / PW'(LB)) * PW'(LB);
  endfunction

  function automatic logic [PW-1:0] rand_addr();
    logic [PW-1:0] a;
    a = {24'd0, $urandom};
    return a;
  endfunction

  task automatic wait_bus_req(input string tag);
    int n;
    n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus_req, 1'b1);
  endtask

  task automatic respond(input int lat, input logic [LW-1:0] line, input bit err);
    for (int i = 0; i < lat; i++) begin
      chk("bus_req_held", bus_req, 1'b1);
      @(negedge clk);
    end
    bus_ack = 1'b1;
    bus_rdata = line;
    bus_error = err;
    @(negedge clk);
    bus_ack = 1'b0;
    bus_error = 1'b0;
    bus_rdata = rand_line();
  endtask

  task automatic check_acks(input string tag, input int who, input logic [LW-1:0] line,
                            input bit err, input logic [PW-1:0] paddr);
    logic [LW-1:0] el;
    int idx;
    el = err ? {LW{1'b0}} : line;
    idx = int'((paddr % PW'(LB)) / PW'(8));
    chk({tag, "_iack"}, imem_ack, who == 0);
    chk({tag, "_dack"}, dmem_ack, who == 1);
    chk({tag, "_pack"}, ptw_mem_ack, who == 2);
    chk({tag, "_busreq_resp"}, bus_req, 1'b0);
    if (who == 0) begin
      chk({tag, "_idata"}, imem_data, el);
      chk({tag, "_ierr"}, imem_error, err);
    end else if (who == 1) begin
      chk({tag, "_ddata"}, dmem_rdata, el);
      chk({tag, "_derr"}, dmem_error, err);
    end else begin
      chk({tag, "_pdata"}, ptw_mem_data, el[idx*64 +: 64]);
      chk({tag, "_perr"}, ptw_mem_error, err);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] line;
    int w;
    rst_n = 1'b0;
    imem_req = 1'b0; imem_addr = '0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    dmem_is_amo = 1'b0; dmem_amo_op = 5'd0;
    ptw_mem_req = 1'b0; ptw_mem_addr = '0;
    bus_ack = 1'b0; bus_rdata = '0; bus_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_addr", bus_addr, '0);
    chk("rst_acks", {imem_ack, dmem_ack, ptw_mem_ack}, 3'b000);
    chk("rst_idata", imem_data, '0);
    chk("rst_ddata", dmem_rdata, '0);
    chk("rst_pdata", ptw_mem_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single imem read
    imem_addr = 56'h8000_0040; imem_req = 1'b1; line = rand_line();
    @(negedge clk);
    chk("t1_latency", bus_req, 1'b1);
    w = pick(3'b001); last_grant = w;
    chk("t1_addr", bus_addr, 56'h8000_0040);
    chk("t1_we", bus_we, 1'b0);
    respond(5, line, 1'b0);
    imem_req = 1'b0;
    check_acks("t1", w, line, 1'b0, '0);
    @(negedge clk);
    chk("t1_pulse", imem_ack, 1'b0);
    chk("t1_hold", imem_data, line);

    // PTW word select
    ptw_mem_addr = 56'h8000_1018; line = rand_line(); line[3*64 +: 64] = 64'h0000_0000_2000_00CF;
    ptw_mem_req = 1'b1;
    @(negedge clk);
    w = pick(3'b100); last_grant = w;
    chk("t2_addr", bus_addr, 56'h8000_1000);
    respond(2, line, 1'b0);
    ptw_mem_req = 1'b0;
    chk("t2_pte", ptw_mem_data, 64'h0000_0000_2000_00CF);
    check_acks("t2", w, line, 1'b0, ptw_mem_addr);
    @(negedge clk);

    // DMEM AMO write
    dmem_addr = 56'h9000_007F; dmem_we = 1'b1; dmem_is_amo = 1'b1; dmem_amo_op = 5'h02;
    dmem_wdata = rand_line(); dmem_req = 1'b1; line = rand_line();
    @(negedge clk);
    w = pick(3'b010); last_grant = w;
    chk("t3_addr", bus_addr, 56'h9000_0040);
    chk("t3_we", bus_we, 1'b1);
    chk("t3_amo", bus_is_amo, 1'b1);
    chk("t3_op", bus_amo_op, 5'h02);
    chk("t3_wdata", bus_wdata, dmem_wdata);
    respond(1, line, 1'b0);
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_is_amo = 1'b0; dmem_amo_op = 5'd0;
    check_acks("t3", w, line, 1'b0, '0);
    @(negedge clk);

    // All three held from reset: fair rotation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; last_grant = 2;
    imem_addr = 56'h1000; dmem_addr = 56'h2040; ptw_mem_addr = 56'h3008;
    imem_req = 1'b1; dmem_req = 1'b1; ptw_mem_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [PW-1:0] ea;
      int g;
      wait_bus_req("t4_req");
      g = pick(3'b111); last_grant = g;
      ea = (g == 0) ? line_base(imem_addr) : (g == 1) ? line_base(dmem_addr) : line_base(ptw_mem_addr);
      chk("t4_grant", bus_addr, ea);
      line = rand_line();
      respond(1, line, 1'b0);
      check_acks("t4", g, line, 1'b0, ptw_mem_addr);
      @(negedge clk);
      chk("t4_pulse", {imem_ack, dmem_ack, ptw_mem_ack}, 3'b000);
      chk("t4_idle_busreq", bus_req, 1'b0);
    end
    imem_req = 1'b0; dmem_req = 1'b0; ptw_mem_req = 1'b0;
    repeat (2) @(negedge clk);

    // Bus error on dmem read
    dmem_addr = rand_addr(); dmem_req = 1'b1; line = rand_line();
    @(negedge clk);
    w = pick(3'b010); last_grant = w;
    chk("t5_addr", bus_addr, line_base(dmem_addr));
    respond(0, line, 1'b1);
    dmem_req = 1'b0;
    check_acks("t5", w, line, 1'b1, '0);
    @(negedge clk);

    // Stray bus_ack while idle
    bus_ack = 1'b1; bus_rdata = rand_line();
    @(negedge clk);
    bus_ack = 1'b0;
    chk("stray_acks", {imem_ack, dmem_ack, ptw_mem_ack}, 3'b000);
    chk("stray_busreq", bus_req, 1'b0);

    // Reset while BUSY
    imem_addr = rand_addr(); ptw_mem_addr = rand_addr();
    imem_req = 1'b1; ptw_mem_req = 1'b1;
    @(negedge clk);
    w = pick(3'b101); last_grant = w;
    chk("t6_first", bus_addr, (w == 0) ? line_base(imem_addr) : line_base(ptw_mem_addr));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_busreq", bus_req, 1'b0);
    chk("t6_async_addr", bus_addr, '0);
    chk("t6_async_acks", {imem_ack, dmem_ack, ptw_mem_ack}, 3'b000);
    chk("t6_async_data", {ptw_mem_data, dmem_rdata[63:0], imem_data[63:0]}, '0);
    @(negedge clk);
    rst_n = 1'b1; last_grant = 2;
    @(negedge clk);
    w = pick(3'b101); last_grant = w;
    chk("t6_after_rst", bus_addr, (w == 0) ? line_base(imem_addr) : line_base(ptw_mem_addr));
    line = rand_line();
    respond(0, line, 1'b0);
    imem_req = 1'b0; ptw_mem_req = 1'b0;
    check_acks("t6", w, line, 1'b0, ptw_mem_addr);
    @(negedge clk);

    // Randomized traffic, including masters dropping req while busy
    for (int r = 0; r < 10; r++) begin
      bit [2:0] rq;
      bit drop;
      int lat, g;
      logic [PW-1:0] ea;
      rq = 3'($urandom_range(1, 7));
      drop = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 4);
      imem_addr = rand_addr(); dmem_addr = rand_addr(); ptw_mem_addr = rand_addr();
      dmem_we = 1'($urandom_range(0, 1)); dmem_wdata = rand_line();
      imem_req = rq[0]; dmem_req = rq[1]; ptw_mem_req = rq[2];
      @(negedge clk);
      chk("r_latency", bus_req, 1'b1);
      g = pick(rq); last_grant = g;
      ea = (g == 0) ? line_base(imem_addr) : (g == 1) ? line_base(dmem_addr) : line_base(ptw_mem_addr);
      chk("r_addr", bus_addr, ea);
      chk("r_we", bus_we, (g == 1) ? dmem_we : 1'b0);
      chk("r_wdata", bus_wdata, (g == 1) ? dmem_wdata : '0);
      if (drop) begin
        imem_req = 1'b0; dmem_req = 1'b0; ptw_mem_req = 1'b0;
      end
      line = rand_line();
      respond(lat, line, 1'b0);
      imem_req = 1'b0; dmem_req = 1'b0; ptw_mem_req = 1'b0;
      check_acks("r", g, line, 1'b0, ptw_mem_addr);
      @(negedge clk);
    end
    dmem_we = 1'b0;

`ifdef NEBULA_ARB_TIMEOUT_EN
    // Watchdog: no bus_ack ever arrives
    begin
      int n;
      imem_addr = rand_addr(); imem_req = 1'b1;
      @(negedge clk);
      last_grant = pick(3'b001);
      chk("to_req", bus_req, 1'b1);
      n = 0;
      while (imem_ack !== 1'b1 && n < 4 * TO) begin
        @(negedge clk);
        n++;
      end
      imem_req = 1'b0;
      chk("to_ack", imem_ack, 1'b1);
      chk("to_err", imem_error, 1'b1);
      chk("to_data", imem_data, '0);
      chk("to_busreq", bus_req, 1'b0);
      bus_ack = 1'b1; bus_rdata = rand_line();
      @(negedge clk);
      bus_ack = 1'b0;
      @(negedge clk);
      chk("to_late_ack", {imem_ack, dmem_ack, ptw_mem_ack}, 3'b000);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
